// File: rtl/wb_stage.sv
// Writeback stage: takes retiring instructions from MEM, waits on data-memory
// responses for loads, extends load data and drives the register file write port.
module wb_stage #(
   parameter int unsigned LOAD_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_regwrite,
   input  logic [4:0]  mem_rd,
   input  logic        mem_is_load,
   input  logic [2:0]  mem_funct3,
   input  logic [1:0]  mem_addr_lo,
   input  logic [31:0] mem_alu_result,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        regwrite,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data,
   output logic        misalign_fault,
   output logic        load_fault,
   output logic        spurious_rsp,
   output logic [31:0] retired
);

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

   localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [4:0]  rd_q;
   logic        rw_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        mem_ready_q;
   logic        regwrite_q;
   logic [4:0]  write_reg_q;
   logic [31:0] write_data_q;
   logic        misalign_q;
   logic        load_fault_q;
   logic        spurious_q;
   logic [31:0] retired_q;

   logic        load_bad_s;
   logic [31:0] shifted_s;
   logic [31:0] load_data_s;

   // Classify the incoming load: misaligned or illegal funct3 is dropped.
   always_comb begin
      load_bad_s = 1'b1;
      case (mem_funct3)
         3'b000, 3'b100: load_bad_s = 1'b0;
         3'b001, 3'b101: load_bad_s = (mem_addr_lo == 2'd3);
         3'b010:         load_bad_s = (mem_addr_lo != 2'd0);
         default:        load_bad_s = 1'b1;
      endcase
   end

   // Align the response word to the captured offset and extend by load type.
   always_comb begin
      shifted_s   = dmem_rdata >> {off_q, 3'b000};
      load_data_s = 32'h0000_0000;
      case (f3_q)
         3'b000:  load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
         3'b001:  load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
         3'b010:  load_data_s = dmem_rdata;
         3'b100:  load_data_s = {24'h00_0000, shifted_s[7:0]};
         3'b101:  load_data_s = {16'h0000, shifted_s[15:0]};
         default: load_data_s = 32'h0000_0000;
      endcase
   end

   // Handshake FSM with all outputs registered; pulses default low each cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         rd_q         <= 5'd0;
         rw_q         <= 1'b0;
         f3_q         <= 3'd0;
         off_q        <= 2'd0;
         mem_ready_q  <= 1'b0;
         regwrite_q   <= 1'b0;
         write_reg_q  <= 5'd0;
         write_data_q <= 32'h0000_0000;
         misalign_q   <= 1'b0;
         load_fault_q <= 1'b0;
         spurious_q   <= 1'b0;
         retired_q    <= 32'h0000_0000;
      end else begin
         regwrite_q   <= 1'b0;
         misalign_q   <= 1'b0;
         load_fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               mem_ready_q <= 1'b1;
               if (dmem_rvalid) begin
                  spurious_q <= 1'b1;
               end
               if (mem_valid && mem_ready_q) begin
                  if (!mem_is_load) begin
                     regwrite_q   <= mem_regwrite && (mem_rd != 5'd0);
                     write_reg_q  <= mem_rd;
                     write_data_q <= mem_alu_result;
                     retired_q    <= retired_q + 32'd1;
                  end else if (load_bad_s) begin
                     misalign_q <= 1'b1;
                  end else begin
                     rd_q        <= mem_rd;
                     rw_q        <= mem_regwrite;
                     f3_q        <= mem_funct3;
                     off_q       <= mem_addr_lo;
                     cnt_q       <= 8'd0;
                     state_q     <= WAIT_LOAD;
                     mem_ready_q <= 1'b0;
                  end
               end
            end
            WAIT_LOAD: begin
               if (dmem_rvalid) begin
                  // A response in the final wait cycle still completes the load.
                  regwrite_q   <= rw_q && (rd_q != 5'd0);
                  write_reg_q  <= rd_q;
                  write_data_q <= load_data_s;
                  retired_q    <= retired_q + 32'd1;
                  state_q      <= IDLE;
                  mem_ready_q  <= 1'b1;
               end else if (cnt_q == TMO_LAST) begin
                  load_fault_q <= 1'b1;
                  state_q      <= IDLE;
                  mem_ready_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q     <= IDLE;
               mem_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_ready      = mem_ready_q;
   assign regwrite       = regwrite_q;
   assign write_reg      = write_reg_q;
   assign write_data     = write_data_q;
   assign misalign_fault = misalign_q;
   assign load_fault     = load_fault_q;
   assign spurious_rsp   = spurious_q;
   assign retired        = retired_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RISC-V core. It accepts completed instructions from the MEM stage over a valid/ready handshake and waits on variable-latency data-memory responses for loads. It sign- or zero-extends load data by funct3 and byte offset, then drives the register file write port (regwrite, write_reg, write_data) from registered outputs. It also flags misaligned and timed-out loads and counts retired instructions.

## Interface

Parameters:
- LOAD_TIMEOUT, default 16: maximum number of WAIT_LOAD cycles without dmem_rvalid before the load is abandoned; legal range 1..255.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  stage can accept; a transfer occurs when mem_valid && mem_ready
- mem_regwrite  in  1  instruction writes rd
- mem_rd  in  5  destination register
- mem_is_load  in  1  instruction is a load
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_addr_lo  in  2  byte offset of the load address
- mem_alu_result  in  32  result for non-load instructions
- dmem_rvalid  in  1  data-memory read response valid
- dmem_rdata  in  32  aligned 32-bit word from data memory
- regwrite  out  1  register file write enable, registered
- write_reg  out  5  register file rd, registered
- write_data  out  32  register file data, registered
- misalign_fault  out  1  one-cycle pulse: a misaligned load or an illegal funct3 was dropped
- load_fault  out  1  one-cycle pulse: a load timed out
- spurious_rsp  out  1  sticky; set when dmem_rvalid arrives in IDLE; cleared only by reset
- retired  out  32  count of instructions completed without a fault; wraps modulo 2^32

## Operation

- States are IDLE and WAIT_LOAD. Reset forces IDLE, and every output is 0.
- mem_ready is 1 in IDLE and 0 in WAIT_LOAD.
- IDLE, transfer of a non-load:
  - Next cycle: regwrite = mem_regwrite && (mem_rd != 0), write_reg = mem_rd, write_data = mem_alu_result.
  - retired increments by 1.
  - State stays IDLE.
- IDLE, transfer of a load:
  - If misaligned (LH/LHU with offset 3; LW with offset != 0) or funct3 is not one of the five legal codes: no write, misalign_fault pulses next cycle, retired is unchanged, state stays IDLE.
  - Otherwise: capture rd, regwrite, funct3 and offset; clear the timeout counter; go to WAIT_LOAD.
- WAIT_LOAD with dmem_rvalid = 1:
  - Extract the data:
    - Byte loads use dmem_rdata[8*off+7 : 8*off].
    - Halfword loads use dmem_rdata[8*off+15 : 8*off].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next cycle: regwrite (gated by captured regwrite && rd != 0), write_reg, write_data are driven; retired increments.
  - Return to IDLE.
- WAIT_LOAD without dmem_rvalid:
  - The counter increments each cycle.
  - In the LOAD_TIMEOUT-th such cycle, return to IDLE; load_fault pulses next cycle; no write; retired is unchanged.
- dmem_rvalid in IDLE is ignored for data and sets spurious_rsp. dmem_rvalid in the same cycle that a load is accepted is treated as in IDLE.
- When regwrite is 0, write_reg and write_data still update; the register file ignores them.
- Asynchronous reset mid-load abandons the load: no write, no fault pulse.

## Timing

- Non-load: accepted in cycle N → regwrite in N+1. Throughput is one per cycle, and back-to-back transfers are legal.
- Load: accepted in N; mem_ready = 0 from N+1. If rvalid arrives in cycle M ≥ N+1, regwrite is high in M+1, mem_ready returns to 1 in M+1, and a new transfer may occur in M+1.
- Timeout: with no rvalid, WAIT_LOAD occupies N+1 .. N+LOAD_TIMEOUT; load_fault and mem_ready = 1 occur in N+LOAD_TIMEOUT+1. If rvalid arrives in cycle N+LOAD_TIMEOUT, it wins over the timeout.
- regwrite, misalign_fault and load_fault are each high for exactly one cycle per event and are never high together.
- retired updates in the same cycle its corresponding regwrite slot appears.

## Test plan

- Reset, then three back-to-back non-loads (rd = 1, 2, 0; results 0x11, 0x22, 0x33) → regwrite 1, 1, 0 in consecutive cycles; write_data 0x11, 0x22; retired = 3.
- LB, offset 2, dmem_rdata 0x12_80_34_56, rvalid 3 cycles after acceptance → write_data 0xFFFFFF80 one cycle after rvalid; mem_ready low for exactly 3 cycles.
- LHU, offset 2, rdata 0x8001_0000 → 0x00008001. LW, offset 0, rdata 0xDEADBEEF → 0xDEADBEEF.
- LW with offset 1, then LH with offset 3 → misalign_fault pulses twice; no regwrite; retired unchanged; mem_ready stays 1.
- LOAD_TIMEOUT = 4, load with no rvalid → load_fault pulses exactly 5 cycles after acceptance; a late rvalid afterwards sets spurious_rsp.
- Reset asserted during WAIT_LOAD → all outputs 0 immediately, state IDLE; a subsequent rvalid produces no write and sets spurious_rsp.
